// File: rtl/border_collision_if.sv
// ---------------------------------------------------------------------------
// border_collision_if
//   Bundles the per-pixel overlap flags, the frame marker, the acknowledge
//   handshake and the hit report of border_collision.
//
//   Signals
//     startOfFrame         single-cycle pulse on the first pixel of a frame
//     draw_ball            ball object covers the current pixel
//     draw_*_boarder       current pixel lies on the top/bottom/left/right border
//     collision_ack        ball controller consumed the reported hit
//     hit_valid            a frame hit is reported and held until acknowledged
//     hit_dir[3:0]         hit sides {top,bottom,left,right}
//     hit_count[7:0]       total reported hits, saturating at 255
//
//   Modports
//     master  drives the pixel flags and ack, observes the report
//     slave   the collision detector itself
// ---------------------------------------------------------------------------
interface border_collision_if;
    logic       startOfFrame;
    logic       draw_ball;
    logic       draw_top_boarder;
    logic       draw_bottom_boarder;
    logic       draw_left_boarder;
    logic       draw_right_boarder;
    logic       collision_ack;
    logic       hit_valid;
    logic [3:0] hit_dir;
    logic [7:0] hit_count;

    modport master (
        output startOfFrame, draw_ball,
               draw_top_boarder, draw_bottom_boarder,
               draw_left_boarder, draw_right_boarder,
               collision_ack,
        input  hit_valid, hit_dir, hit_count
    );

    modport slave (
        input  startOfFrame, draw_ball,
               draw_top_boarder, draw_bottom_boarder,
               draw_left_boarder, draw_right_boarder,
               collision_ack,
        output hit_valid, hit_dir, hit_count
    );
endinterface

// File: rtl/border_collision.sv
// ---------------------------------------------------------------------------
// border_collision
//   Accumulates ball/border overlaps over a video frame and, at the frame
//   boundary, reports which borders were touched. The report is held until
//   the ball controller acknowledges it, after which COOLDOWN_FRAMES frame
//   boundaries are ignored before collection resumes.
//
//   Parameters
//     COOLDOWN_FRAMES  frames ignored after an acknowledged hit (0..15)
//
//   Ports
//     clk      pixel clock
//     resetN   asynchronous, active-low reset
//     bus      border_collision_if.slave (pixel flags, ack, hit report)
// ---------------------------------------------------------------------------
module border_collision #(
    parameter int unsigned COOLDOWN_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    border_collision_if.slave         bus
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        REPORT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_FRAMES);

    state_t     state_q,     state_d;
    logic [3:0] pending_q,   pending_d;
    logic [3:0] cd_q,        cd_d;
    logic       hit_valid_q, hit_valid_d;
    logic [3:0] hit_dir_q,   hit_dir_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic [3:0] sample;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= COLLECT;
            pending_q   <= 4'b0000;
            cd_q        <= 4'd0;
            hit_valid_q <= 1'b0;
            hit_dir_q   <= 4'b0000;
            hit_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cd_q        <= cd_d;
            hit_valid_q <= hit_valid_d;
            hit_dir_q   <= hit_dir_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_comb begin
        // This cycle's overlap, bit order {top,bottom,left,right}
        sample = bus.draw_ball ? {bus.draw_top_boarder,  bus.draw_bottom_boarder,
                                  bus.draw_left_boarder, bus.draw_right_boarder}
                               : 4'b0000;

        state_d     = state_q;
        pending_d   = pending_q;
        cd_d        = cd_q;
        hit_valid_d = hit_valid_q;
        hit_dir_d   = hit_dir_q;
        hit_count_d = hit_count_q;

        unique case (state_q)
            COLLECT: begin
                if (bus.startOfFrame) begin
                    if (pending_q != 4'b0000) begin
                        hit_valid_d = 1'b1;
                        hit_dir_d   = pending_q;
                        if (hit_count_q != 8'hFF) begin
                            hit_count_d = hit_count_q + 8'd1;
                        end
                        // The new frame is not collected while reporting
                        pending_d   = 4'b0000;
                        state_d     = REPORT;
                    end else begin
                        // A sample on the frame-start pixel belongs to the new frame
                        pending_d   = sample;
                    end
                end else begin
                    pending_d = pending_q | sample;
                end
            end

            REPORT: begin
                pending_d = 4'b0000;
                // An ack coinciding with startOfFrame is only an ack; that
                // frame boundary does not count toward the cooldown.
                if (bus.collision_ack) begin
                    hit_valid_d = 1'b0;
                    hit_dir_d   = 4'b0000;
                    cd_d        = CD_LOAD;
                    state_d     = (CD_LOAD == 4'd0) ? COLLECT : COOLDOWN;
                end
            end

            COOLDOWN: begin
                pending_d = 4'b0000;
                if (bus.startOfFrame) begin
                    cd_d = cd_q - 4'd1;
                    if (cd_q <= 4'd1) begin
                        state_d = COLLECT;
                    end
                end
            end

            default: begin
                state_d   = COLLECT;
                pending_d = 4'b0000;
            end
        endcase
    end

    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_dir   = hit_dir_q;
    assign bus.hit_count = hit_count_q;

endmodule

// File: doc/border_collision.md
BORDER_COLLISION -- requirements
Module: border_collision

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 2, sets the number of frames ignored after an acknowledged hit (range 0-15).
REQ-002 clk  input  1  system pixel clock.
REQ-003 resetN  input  1  asynchronous, active-low reset.
REQ-004 startOfFrame  input  1  single-cycle pulse marking the first pixel of a frame.
REQ-005 draw_ball  input  1  ball object covers the current pixel.
REQ-006 draw_top_boarder  input  1  current pixel lies on the top border line.
REQ-007 draw_bottom_boarder  input  1  current pixel lies on the bottom border line.
REQ-008 draw_left_boarder  input  1  current pixel lies on the left border line.
REQ-009 draw_right_boarder  input  1  current pixel lies on the right border line.
REQ-010 collision_ack  input  1  ball controller consumed the reported hit.
REQ-011 hit_valid  output  1  a frame hit is reported and held until acknowledged.
REQ-012 hit_dir  output  4  hit sides {top,bottom,left,right}; meaningful while hit_valid=1.
REQ-013 hit_count  output  8  total reported hits, saturating.

Function
REQ-014 All inputs SHALL be sampled on posedge clk, and draw_ball SHALL be pixel-aligned with the border flags in the same cycle.
REQ-015 The block SHALL run a three-state FSM: COLLECT, REPORT, COOLDOWN.
REQ-016 In COLLECT, each cycle the block SHALL OR draw_ball AND each border flag into the matching bit of a 4-bit pending register.
REQ-017 In COLLECT, on startOfFrame with pending!=0, the block SHALL load hit_dir<=pending, set hit_valid<=1, increment hit_count, and enter REPORT on the next edge.
REQ-018 In COLLECT, on startOfFrame the pending register SHALL be reloaded with only that cycle's overlap sample, so a sample coincident with startOfFrame belongs to the new frame.
REQ-019 In COLLECT, on startOfFrame with pending==0, the block SHALL stay in COLLECT with no output change.
REQ-020 Latency from the startOfFrame edge that closes a hit frame to hit_valid=1 SHALL be exactly 1 clock.
REQ-021 In REPORT, hit_valid and hit_dir SHALL hold stable until collision_ack=1.
REQ-022 In REPORT and COOLDOWN, border overlaps SHALL be ignored and pending SHALL be held at 0.
REQ-023 On collision_ack in REPORT, hit_valid SHALL go to 0 on the next edge, hit_dir SHALL clear to 0, and the cooldown counter SHALL load COOLDOWN_FRAMES.
REQ-024 On collision_ack in REPORT, the FSM SHALL enter COOLDOWN, or COLLECT directly if COOLDOWN_FRAMES==0.
REQ-025 collision_ack and startOfFrame arriving together in REPORT SHALL be treated as ack only; that startOfFrame SHALL NOT decrement the cooldown counter.
REQ-026 collision_ack outside REPORT SHALL be ignored.
REQ-027 In COOLDOWN, each startOfFrame SHALL decrement the counter, and the FSM SHALL enter COLLECT with pending=0 on the startOfFrame that takes the counter to 0.
REQ-028 Simultaneous overlaps with several borders in one frame (corner) SHALL set several hit_dir bits together.
REQ-029 hit_count SHALL saturate at 255 and never wrap.

Reset
REQ-030 When resetN=0, the block SHALL asynchronously force state=COLLECT, pending=0, cooldown counter=0, hit_valid=0, hit_dir=4'b0000 and hit_count=0.
REQ-031 Reset asserted mid-REPORT or mid-COOLDOWN SHALL discard the hit in progress, and the first frame after resetN rises SHALL be collected normally.

Verification
REQ-032 Ball overlaps draw_left_boarder 3 pixels in frame N, then startOfFrame -> one cycle later hit_valid=1, hit_dir=4'b0010, hit_count=1.
REQ-033 Ball overlaps top and right borders in one frame -> hit_dir=4'b1001 and hit_valid held across 3 frames with no ack.
REQ-034 Ack in REPORT with COOLDOWN_FRAMES=2, overlaps present in the next 3 frames -> no report for 2 frames, and a report after the 3rd frame's closing startOfFrame.
REQ-035 Overlap sample only on the startOfFrame cycle -> no report at that edge, and a report at the following startOfFrame.
REQ-036 Generate 300 acknowledged hits with COOLDOWN_FRAMES=0 -> hit_count=255, stable.
REQ-037 resetN pulsed low while hit_valid=1 -> all outputs 0 immediately, and a clean report on the next hit frame.
